// File: rtl/dsi_packet_sequencer.sv
// dsi_packet_sequencer: emits one DSI packet per request as a byte stream (header, payload, CRC).
// Define DSI_PACKET_SEQUENCER_EOT_EN to append an EoT short packet after every packet.

module dsi_parity (
   input  logic [23:0] data_i,
   output logic [7:0]  ecc_o
);
   // Hamming-style ECC over {WC MSB, WC LSB, DI}; each mask selects one parity bit's coverage.
   always_comb begin
      ecc_o    = 8'h00;
      ecc_o[0] = ^(data_i & 24'hF12CB7);
      ecc_o[1] = ^(data_i & 24'hF2555B);
      ecc_o[2] = ^(data_i & 24'h749A6D);
      ecc_o[3] = ^(data_i & 24'hB8E38E);
      ecc_o[4] = ^(data_i & 24'hDF03F0);
      ecc_o[5] = ^(data_i & 24'hEFFC00);
   end
endmodule

module dsi_crc #(
   parameter int g_max_data_bytes = 1
) (
   input  logic                                     clk_i,
   input  logic                                     rst_n_i,
   input  logic                                     rst_i,
   input  logic                                     valid_i,
   input  logic [$clog2(g_max_data_bytes+1)-1:0]    nbytes_i,
   input  logic [8*g_max_data_bytes-1:0]            data_i,
   output logic [15:0]                              crc_o
);
   logic [15:0] crc_q, crc_d;

   // Reflected CCITT polynomial, LSB of each byte first, seeded with 0xFFFF.
   always_comb begin
      crc_d = crc_q;
      if (rst_i) begin
         crc_d = 16'hFFFF;
      end else if (valid_i) begin
         for (int b = 0; b < g_max_data_bytes; b++) begin
            if (b < int'(nbytes_i)) begin
               for (int i = 0; i < 8; i++) begin
                  crc_d = {1'b0, crc_d[15:1]} ^
                          ((crc_d[0] ^ data_i[8*b+i]) ? 16'h8408 : 16'h0000);
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) crc_q <= 16'hFFFF;
      else          crc_q <= crc_d;
   end

   assign crc_o = crc_q;
endmodule

// state   | meaning
// IDLE    | ready for a request; DI is loaded on the accept cycle
// HDR     | loading WC LSB, WC MSB, ECC
// PAYLOAD | forwarding payload bytes, counting down remaining
// CRC0/1  | loading checksum LSB then MSB
// EOT     | loading the EoT short packet (optional build)
// DONE    | waiting for the final byte to be taken
module dsi_packet_sequencer #(
   parameter int g_wc_bits = 16
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        req_i,
   output logic        req_ready_o,
   input  logic        req_long_i,
   input  logic [1:0]  req_vc_i,
   input  logic [5:0]  req_dt_i,
   input  logic [15:0] req_wc_i,
   input  logic [7:0]  pl_data_i,
   input  logic        pl_valid_i,
   output logic        pl_ready_o,
   output logic [7:0]  out_data_o,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic        out_last_o,
   output logic        busy_o
);
`ifdef DSI_PACKET_SEQUENCER_EOT_EN
   typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAYLOAD, S_CRC0, S_CRC1, S_DONE, S_EOT} state_t;
   localparam state_t S_AFTER  = S_EOT;
   localparam logic   PKT_LAST = 1'b0;
`else
   typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAYLOAD, S_CRC0, S_CRC1, S_DONE} state_t;
   localparam state_t S_AFTER  = S_DONE;
   localparam logic   PKT_LAST = 1'b1;
`endif

   state_t               state_q, state_d;
   logic [1:0]           idx_q, idx_d;
   logic [7:0]           di_q, di_d;
   logic [15:0]          wc_q, wc_d;
   logic                 long_q, long_d;
   logic [7:0]           ecc_q, ecc_d;
   logic [g_wc_bits-1:0] rem_q, rem_d;
   logic                 out_valid_q, out_valid_d;
   logic [7:0]           out_data_q, out_data_d;
   logic                 out_last_q, out_last_d;
   logic                 live_q;

   logic        slot_free, accept, pl_take;
   logic        ld_en, ld_last;
   logic [7:0]  ld_data;
   logic [7:0]  ecc_calc;
   logic [15:0] crc;

   assign slot_free   = !out_valid_q || out_ready_i;
   assign req_ready_o = (state_q == S_IDLE) && live_q;
   assign accept      = req_i && req_ready_o;
   assign pl_ready_o  = (state_q == S_PAYLOAD) && slot_free;
   assign pl_take     = pl_valid_i && pl_ready_o;
   assign busy_o      = (state_q != S_IDLE);
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_last_o  = out_last_q;

   dsi_parity u_parity (
      .data_i ({req_wc_i[15:8], req_wc_i[7:0], req_vc_i, req_dt_i}),
      .ecc_o  (ecc_calc)
   );

   dsi_crc #(.g_max_data_bytes(1)) u_crc (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .rst_i    (accept),
      .valid_i  (pl_take),
      .nbytes_i (1'b1),
      .data_i   (pl_data_i),
      .crc_o    (crc)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      di_d    = di_q;
      wc_d    = wc_q;
      long_d  = long_q;
      ecc_d   = ecc_q;
      rem_d   = rem_q;
      ld_en   = 1'b0;
      ld_last = 1'b0;
      ld_data = 8'h00;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               di_d    = {req_vc_i, req_dt_i};
               wc_d    = req_wc_i;
               long_d  = req_long_i;
               ecc_d   = {2'b00, ecc_calc[5:0]};
               ld_en   = 1'b1;
               ld_data = {req_vc_i, req_dt_i};
               idx_d   = 2'd1;
               state_d = S_HDR;
            end
         end
         S_HDR: begin
            if (slot_free) begin
               ld_en = 1'b1;
               idx_d = idx_q + 2'd1;
               case (idx_q)
                  2'd1:    ld_data = wc_q[7:0];
                  2'd2:    ld_data = wc_q[15:8];
                  2'd3:    ld_data = ecc_q;
                  default: ld_data = di_q;
               endcase
               if (idx_q == 2'd3) begin
                  rem_d = wc_q[g_wc_bits-1:0];
                  if (!long_q) begin
                     ld_last = PKT_LAST;
                     state_d = S_AFTER;
                  end else if (wc_q[g_wc_bits-1:0] == '0) begin
                     state_d = S_CRC0;
                  end else begin
                     state_d = S_PAYLOAD;
                  end
               end
            end
         end
         S_PAYLOAD: begin
            if (pl_take) begin
               ld_en   = 1'b1;
               ld_data = pl_data_i;
               rem_d   = rem_q - 1'b1;
               if (rem_q == g_wc_bits'(1)) state_d = S_CRC0;
            end
         end
         S_CRC0: begin
            if (slot_free) begin
               ld_en   = 1'b1;
               ld_data = crc[7:0];
               state_d = S_CRC1;
            end
         end
         S_CRC1: begin
            if (slot_free) begin
               ld_en   = 1'b1;
               ld_data = crc[15:8];
               ld_last = PKT_LAST;
               state_d = S_AFTER;
            end
         end
`ifdef DSI_PACKET_SEQUENCER_EOT_EN
         S_EOT: begin
            if (slot_free) begin
               ld_en = 1'b1;
               idx_d = idx_q + 2'd1;
               case (idx_q)
                  2'd0:    ld_data = 8'h08;
                  2'd3:    ld_data = 8'h01;
                  default: ld_data = 8'h0F;
               endcase
               if (idx_q == 2'd3) begin
                  ld_last = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
`endif
         S_DONE: begin
            if (slot_free) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output slot: drains when taken, holds while stalled, refills only when free.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      if (slot_free) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end
      if (ld_en) begin
         out_valid_d = 1'b1;
         out_data_d  = ld_data;
         out_last_d  = ld_last;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= S_IDLE;
         idx_q       <= 2'd0;
         di_q        <= 8'h00;
         wc_q        <= 16'h0000;
         long_q      <= 1'b0;
         ecc_q       <= 8'h00;
         rem_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= 8'h00;
         out_last_q  <= 1'b0;
         live_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         di_q        <= di_d;
         wc_q        <= wc_d;
         long_q      <= long_d;
         ecc_q       <= ecc_d;
         rem_q       <= rem_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         live_q      <= 1'b1;
      end
   end
endmodule

// File: tb/tb_dsi_packet_sequencer.sv
// tb_dsi_packet_sequencer: directed packets with hand-computed header/ECC/CRC bytes,
// optional backpressure, and an asynchronous reset in the middle of a payload.

module tb_dsi_packet_sequencer;
   logic        clk = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        req_i = 1'b0;
   logic        req_ready_o;
   logic        req_long_i = 1'b0;
   logic [1:0]  req_vc_i = 2'd0;
   logic [5:0]  req_dt_i = 6'd0;
   logic [15:0] req_wc_i = 16'd0;
   logic [7:0]  pl_data_i = 8'd0;
   logic        pl_valid_i = 1'b0;
   logic        pl_ready_o;
   logic [7:0]  out_data_o;
   logic        out_valid_o;
   logic        out_ready_i = 1'b1;
   logic        out_last_o;
   logic        busy_o;

   int total = 0;
   int bad = 0;
   logic [7:0] exp_q[$];
   logic [7:0] pl_q[$];

   always #5 clk = ~clk;

   dsi_packet_sequencer #(.g_wc_bits(16)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n_i),
      .req_i       (req_i),
      .req_ready_o (req_ready_o),
      .req_long_i  (req_long_i),
      .req_vc_i    (req_vc_i),
      .req_dt_i    (req_dt_i),
      .req_wc_i    (req_wc_i),
      .pl_data_i   (pl_data_i),
      .pl_valid_i  (pl_valid_i),
      .pl_ready_o  (pl_ready_o),
      .out_data_o  (out_data_o),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_last_o  (out_last_o),
      .busy_o      (busy_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic add_eot();
`ifdef DSI_PACKET_SEQUENCER_EOT_EN
      exp_q.push_back(8'h08);
      exp_q.push_back(8'h0F);
      exp_q.push_back(8'h0F);
      exp_q.push_back(8'h01);
`endif
   endtask

   task automatic load_nine();
      pl_q.delete();
      for (int i = 0; i < 9; i++) pl_q.push_back(8'h31 + 8'(i));
   endtask

   // Entered and left at posedge+1; DUT outputs are sampled on the falling edge.
   task automatic run_pkt(input string tag, input logic lng, input logic [1:0] vc,
                          input logic [5:0] dt, input logic [15:0] wc, input bit rnd,
                          input int stop_k);
      int k, pi, cyc, n, acc_cyc, first_cyc, last_cyc, pl_pulses;
      bit accepted, stalled, early_pl;
      logic [7:0] held_d;
      logic held_l;
      n = exp_q.size();
      k = 0; pi = 0; cyc = 0; acc_cyc = -1; first_cyc = -1; last_cyc = -1; pl_pulses = 0;
      accepted = 0; stalled = 0; early_pl = 0; held_d = 8'h00; held_l = 1'b0;
      req_i = 1'b1; req_long_i = lng; req_vc_i = vc; req_dt_i = dt; req_wc_i = wc;
      pl_valid_i = (pl_q.size() > 0);
      pl_data_i = (pl_q.size() > 0) ? pl_q[0] : 8'h00;
      out_ready_i = 1'b1;
      while (k < n && cyc < 400 && !(stop_k > 0 && k >= stop_k)) begin
         @(negedge clk);
         cyc++;
         if (stalled) begin
            chk({tag, " stall valid"}, 32'(out_valid_o), 32'd1);
            chk({tag, " stall data"}, 32'(out_data_o), 32'(held_d));
            chk({tag, " stall last"}, 32'(out_last_o), 32'(held_l));
         end
         if (req_i && req_ready_o && !accepted) begin
            accepted = 1;
            acc_cyc = cyc;
         end
         if (out_valid_o && first_cyc < 0) first_cyc = cyc;
         if (pl_ready_o && k < 3) early_pl = 1;
         if (pl_ready_o) pl_pulses++;
         if (pl_valid_i && pl_ready_o) pi++;
         stalled = out_valid_o && !out_ready_i;
         held_d = out_data_o;
         held_l = out_last_o;
         if (out_valid_o && out_ready_i) begin
            chk($sformatf("%s byte%0d", tag, k), 32'(out_data_o), 32'(exp_q[k]));
            chk($sformatf("%s last%0d", tag, k), 32'(out_last_o), 32'(k == n - 1));
            k++;
            last_cyc = cyc;
         end
         @(posedge clk);
         #1;
         if (accepted) req_i = 1'b0;
         pl_valid_i = (pi < pl_q.size()) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
         pl_data_i = (pi < pl_q.size()) ? pl_q[pi] : 8'h00;
         out_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (stop_k == 0) begin
         pl_valid_i = 1'b0;
         out_ready_i = 1'b1;
         chk({tag, " byte count"}, 32'(k), 32'(n));
         chk({tag, " latency"}, 32'(first_cyc - acc_cyc), 32'd1);
         if (!rnd) chk({tag, " span"}, 32'(last_cyc - first_cyc + 1), 32'(n));
         chk({tag, " early pl_ready"}, 32'(early_pl), 32'd0);
         chk({tag, " payload used"}, 32'(pi), 32'(pl_q.size()));
         if (pl_q.size() == 0) chk({tag, " pl_ready pulses"}, 32'(pl_pulses), 32'd0);
         @(negedge clk);
         chk({tag, " ready after"}, 32'(req_ready_o), 32'd1);
         chk({tag, " valid after"}, 32'(out_valid_o), 32'd0);
         chk({tag, " busy after"}, 32'(busy_o), 32'd0);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state.
      #12;
      chk("rst out_valid", 32'(out_valid_o), 32'd0);
      chk("rst out_data", 32'(out_data_o), 32'd0);
      chk("rst out_last", 32'(out_last_o), 32'd0);
      chk("rst req_ready", 32'(req_ready_o), 32'd0);
      chk("rst pl_ready", 32'(pl_ready_o), 32'd0);
      chk("rst busy", 32'(busy_o), 32'd0);
      @(negedge clk);
      rst_n_i = 1'b1;
      @(negedge clk);
      chk("post-rst req_ready", 32'(req_ready_o), 32'd1);
      @(posedge clk);
      #1;

      // Short DCS write.
      exp_q = '{8'h05, 8'h11, 8'h00, 8'h36};
      add_eot();
      pl_q.delete();
      run_pkt("short", 1'b0, 2'd0, 6'h05, 16'h0011, 1'b0, 0);

      // Long packet, no payload: CRC is the untouched seed.
      exp_q = '{8'h39, 8'h00, 8'h00, 8'h0F, 8'hFF, 8'hFF};
      add_eot();
      pl_q.delete();
      run_pkt("long0", 1'b1, 2'd0, 6'h39, 16'h0000, 1'b0, 0);

      // Long packet "123456789".
      exp_q = '{8'h29, 8'h09, 8'h00, 8'h23, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                8'h36, 8'h37, 8'h38, 8'h39, 8'h91, 8'h6F};
      add_eot();
      load_nine();
      run_pkt("long9", 1'b1, 2'd0, 6'h29, 16'd9, 1'b0, 0);

      // Same packet under backpressure and payload gaps.
      run_pkt("bp9", 1'b1, 2'd0, 6'h29, 16'd9, 1'b1, 0);

      // Short packet on VC1 exercising the top WC bit, with backpressure.
      exp_q = '{8'h55, 8'h00, 8'h80, 8'h34};
      add_eot();
      pl_q.delete();
      run_pkt("vc1", 1'b0, 2'd1, 6'h15, 16'h8000, 1'b1, 0);

      // Reset after 4 header + 3 payload bytes.
      exp_q = '{8'h29, 8'h09, 8'h00, 8'h23, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                8'h36, 8'h37, 8'h38, 8'h39, 8'h91, 8'h6F};
      load_nine();
      run_pkt("midrst", 1'b1, 2'd0, 6'h29, 16'd9, 1'b0, 7);
      #1;
      chk("midrst pre valid", 32'(out_valid_o), 32'd1);
      rst_n_i = 1'b0;
      #1;
      chk("midrst out_valid", 32'(out_valid_o), 32'd0);
      chk("midrst busy", 32'(busy_o), 32'd0);
      chk("midrst req_ready", 32'(req_ready_o), 32'd0);
      chk("midrst pl_ready", 32'(pl_ready_o), 32'd0);
      req_i = 1'b0;
      pl_valid_i = 1'b0;
      repeat (2) @(negedge clk);
      chk("midrst held", 32'(out_valid_o), 32'd0);
      rst_n_i = 1'b1;
      @(posedge clk);
      #1;

      exp_q = '{8'h05, 8'h11, 8'h00, 8'h36};
      add_eot();
      pl_q.delete();
      run_pkt("after-rst short", 1'b0, 2'd0, 6'h05, 16'h0011, 1'b0, 0);

      exp_q = '{8'h29, 8'h09, 8'h00, 8'h23, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                8'h36, 8'h37, 8'h38, 8'h39, 8'h91, 8'h6F};
      add_eot();
      load_nine();
      run_pkt("after-rst long9", 1'b1, 2'd0, 6'h29, 16'd9, 1'b0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
